// File: rtl/read_axi_pkg.sv
// Shared types and helpers for the read AXI arbiter: FSM encoding, counter width,
// and rid decode helpers.
package read_axi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam int unsigned CNTW     = 4;
    localparam int unsigned RID_MAXW = 16;

    // Low idxw bits of rid select the requester
    function automatic int unsigned idx_of(input logic [RID_MAXW-1:0] rid,
                                           input int unsigned         idxw);
        logic [RID_MAXW-1:0] mask;
        mask = (RID_MAXW'(1) << idxw) - RID_MAXW'(1);
        return 32'(rid & mask);
    endfunction

    // A rid is routable only if the whole id names an existing requester
    function automatic logic rid_valid(input logic [RID_MAXW-1:0] rid,
                                       input int unsigned         nreq);
        return 32'(rid) < nreq;
    endfunction

endpackage

// File: rtl/read_axi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDX  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDX-1:0]  ptr,
    output logic [IDX-1:0]  gnt_idx,
    output logic            any
);

    int unsigned cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(ptr) + k) % NREQ;
            if (req[IDX'(cand)]) begin
                gnt_idx = IDX'(cand);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_axi_arbiter.sv
// Shares one AXI read port among NREQ requesters: round-robin AR issue with
// requester-tagged ids, rid-based R steering and per-requester outstanding limits.
module read_axi_arbiter
    import read_axi_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDWID  = 4,
    parameter int unsigned AWID   = 32,
    parameter int unsigned DWID   = 32,
    parameter int unsigned MAXOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_arvalid,
    input  logic [NREQ*AWID-1:0] req_araddr,
    input  logic [NREQ*16-1:0]   req_arbytes,
    output logic [NREQ-1:0]      req_arready,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [AWID-1:0]      araddr,
    output logic [15:0]          arbytes,
    output logic [IDWID-1:0]     arid,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [IDWID-1:0]     rid,
    input  logic                 rlast,
    input  logic [DWID-1:0]      rdata,
    output logic [NREQ-1:0]      req_rvalid,
    input  logic [NREQ-1:0]      req_rready,
    output logic [DWID-1:0]      req_rdata,
    output logic                 req_rlast,
    output logic [NREQ*4-1:0]    outstanding,
    output logic                 err
);

    localparam int unsigned IDX = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic             arvalid_d;
    logic [AWID-1:0]  araddr_d;
    logic [15:0]      arbytes_d;
    logic [IDX-1:0]   gnt_q, gnt_d;
    logic [IDX-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  eligible;
    logic [IDX-1:0]   pick_idx;
    logic             pick_any;
    logic             ar_hs;
    logic             rid_ok;
    logic [IDX-1:0]   r_idx;
    logic             r_done;
    logic             err_d;
    logic [CNTW-1:0]  cnt_q [NREQ];
    logic [CNTW-1:0]  cnt_d [NREQ];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            eligible[i] = req_arvalid[i] && (cnt_q[i] < CNTW'(MAXOUT));
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDX  (IDX)
    ) u_pick (
        .req     (eligible),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // AR FSM: latch a winner in IDLE, hold it in ISSUE until the master accepts
    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid;
        araddr_d    = araddr;
        arbytes_d   = arbytes;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        req_arready = '0;
        ar_hs       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    arvalid_d = 1'b1;
                    araddr_d  = req_araddr[32'(pick_idx)*AWID +: AWID];
                    arbytes_d = req_arbytes[32'(pick_idx)*16 +: 16];
                    gnt_d     = pick_idx;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arready) begin
                    ar_hs              = 1'b1;
                    req_arready[gnt_q] = 1'b1;
                    rr_ptr_d           = gnt_q;
                    arvalid_d          = 1'b0;
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arid = IDWID'(gnt_q);

    // R steering; unroutable ids are sunk so the bus cannot hang
    always_comb begin
        rid_ok     = rid_valid(RID_MAXW'(rid), NREQ);
        r_idx      = IDX'(idx_of(RID_MAXW'(rid), IDX));
        req_rvalid = '0;
        rready     = 1'b1;
        if (rid_ok) begin
            rready            = req_rready[r_idx];
            req_rvalid[r_idx] = rvalid;
        end
        r_done = rvalid && rready && rlast && rid_ok;
    end

    assign req_rdata = rdata;
    assign req_rlast = rlast;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            logic inc, dec;
            inc      = ar_hs && (gnt_q == IDX'(i));
            dec      = r_done && (r_idx == IDX'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
        end
        err_d = err || (rvalid && !rid_ok) || (r_done && (cnt_q[r_idx] == '0));
    end

    genvar g;
    generate
        for (g = 0; g < int'(NREQ); g++) begin : g_out
            assign outstanding[g*4 +: 4] = 4'(cnt_q[g]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arbytes  <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= IDX'(NREQ - 1);
            err      <= 1'b0;
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            arvalid  <= arvalid_d;
            araddr   <= araddr_d;
            arbytes  <= arbytes_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            err      <= err_d;
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
